// File: rtl/lut_layer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lut_layer_sequencer_pkg
// Purpose  : Shared widths, FSM state encoding and config-select codes for
//            the time-multiplexed LogicNets layer evaluator.
// Revision : 1.0 - initial release
// ============================================================================
package lut_layer_sequencer_pkg;

  // Default layer geometry
  localparam int DEF_IN_WIDTH = 16;
  localparam int DEF_IBW      = 2;
  localparam int DEF_FANIN    = 4;
  localparam int DEF_NEURONS  = 16;
  localparam int DEF_OBW      = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Widths derived from the default geometry
  localparam int IDXW   = $clog2(DEF_IN_WIDTH);
  localparam int TAW    = DEF_FANIN * DEF_IBW;
  localparam int NFW    = $clog2(DEF_NEURONS);
  localparam int CFG_AW = NFW + TAW;
  localparam int CFG_DW = max_int(DEF_OBW, IDXW);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic CFG_SEL_TABLE = 1'b0;
  localparam logic CFG_SEL_CONN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/lut_layer_sequencer_table_ram.sv
`default_nettype none
// ============================================================================
// Module   : lut_table_ram
// Purpose  : Shared truth-table store. One synchronous write port, one read
//            port with a registered output. Contents are never reset.
// Revision : 1.0 - initial release
// ============================================================================
module lut_table_ram #(
  parameter int AW    = 12,
  parameter int DW    = 2,
  parameter int DEPTH = 4096
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  // Write port and registered read port share the one clock
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[wr_addr] <= wr_data;
    end
    r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/lut_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lut_layer_sequencer
// Purpose  : Evaluates one sparse LUT layer by walking the neurons one per
//            cycle through a single shared truth-table RAM. Tables and
//            connectivity are loaded at runtime while the block is idle.
// Revision : 1.0 - initial release
// ============================================================================
module lut_layer_sequencer
  import lut_layer_sequencer_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int IBW      = DEF_IBW,
  parameter int FANIN    = DEF_FANIN,
  parameter int NEURONS  = DEF_NEURONS,
  parameter int OBW      = DEF_OBW,
  localparam int C_IDXW    = $clog2(IN_WIDTH),
  localparam int C_TAW     = FANIN * IBW,
  localparam int C_NFW     = $clog2(NEURONS),
  localparam int C_CFG_AW  = C_NFW + C_TAW,
  localparam int C_CFG_DW  = max_int(OBW, C_IDXW)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_WIDTH*IBW-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NEURONS*OBW-1:0]  out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    cfg_we,
  input  logic                    cfg_sel,
  input  logic [C_CFG_AW-1:0]     cfg_addr,
  input  logic [C_CFG_DW-1:0]     cfg_data,
  output logic                    cfg_err,
  output logic                    busy
);

  localparam int C_CONN_AW = $clog2(NEURONS * FANIN);
  // One extra bit on each bound so the comparison is never trivially constant
  localparam logic [C_NFW:0]    C_NEURONS_W  = (C_NFW + 1)'(NEURONS);
  localparam logic [C_IDXW:0]   C_IN_WIDTH_W = (C_IDXW + 1)'(IN_WIDTH);
  localparam logic [C_CFG_AW:0] C_CONN_N_W   = (C_CFG_AW + 1)'(NEURONS * FANIN);
  localparam logic [C_NFW-1:0]  C_LAST       = C_NFW'(NEURONS - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [C_NFW-1:0]        r_cnt;
  logic [IN_WIDTH*IBW-1:0] r_vec;
  logic [C_IDXW-1:0]       r_conn [NEURONS*FANIN];
  logic [NEURONS*OBW-1:0]  r_out_data;
  logic                    r_wr_en;
  logic [C_NFW-1:0]        r_wr_slot;
  logic                    r_cfg_err;

  logic                    w_idle;
  logic                    w_accept;
  logic                    w_in_range;
  logic                    w_cfg_ok;
  logic                    w_tbl_we;
  logic                    w_conn_we;
  logic [C_TAW-1:0]        w_gather;
  logic [C_CFG_AW-1:0]     w_rd_addr;
  logic [OBW-1:0]          w_rd_data;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && in_valid;

  // Config address bound check for whichever store is selected
  always_comb begin
    if (cfg_sel == CFG_SEL_CONN) begin
      w_in_range = ({1'b0, cfg_addr} < C_CONN_N_W);
    end else begin
      w_in_range = ({1'b0, cfg_addr[C_CFG_AW-1:C_TAW]} < C_NEURONS_W);
    end
  end

  assign w_cfg_ok  = cfg_we && w_idle && w_in_range;
  assign w_tbl_we  = w_cfg_ok && (cfg_sel == CFG_SEL_TABLE);
  assign w_conn_we = w_cfg_ok && (cfg_sel == CFG_SEL_CONN);

  // Connectivity flop array; survives reset like the table store
  always_ff @(posedge clk) begin
    if (w_conn_we) begin
      r_conn[cfg_addr[C_CONN_AW-1:0]] <= cfg_data[C_IDXW-1:0];
    end
  end

  // Gather the current neuron's fan-in features into its table address
  for (genvar k = 0; k < FANIN; k++) begin : g_gather
    logic [C_CONN_AW-1:0] w_conn_idx;
    logic [C_IDXW-1:0]    w_feat_idx;
    assign w_conn_idx = C_CONN_AW'(int'(r_cnt) * FANIN + k);
    assign w_feat_idx = r_conn[w_conn_idx];
    assign w_gather[k*IBW +: IBW] = ({1'b0, w_feat_idx} < C_IN_WIDTH_W)
                                    ? IBW'(r_vec >> (int'(w_feat_idx) * IBW))
                                    : '0;
  end

  assign w_rd_addr = {r_cnt, w_gather};

  lut_table_ram #(
    .AW    (C_CFG_AW),
    .DW    (OBW),
    .DEPTH (NEURONS << C_TAW)
  ) u_table_ram (
    .clk     (clk),
    .we      (w_tbl_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data[OBW-1:0]),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid)          w_next = ST_RUN;
      ST_RUN:   if (r_cnt == C_LAST)   w_next = ST_FLUSH;
      ST_FLUSH:                        w_next = ST_OUT;
      ST_OUT:   if (out_ready)         w_next = ST_IDLE;
      default:                         w_next = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    in_ready  = (r_state == ST_IDLE);
    out_valid = (r_state == ST_OUT);
    busy      = (r_state != ST_IDLE);
  end

  // Input vector capture on acceptance; no reset needed
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_vec <= in_data;
    end
  end

  // Neuron counter, delayed write-back of the RAM read and config error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_slot  <= '0;
      r_out_data <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !w_cfg_ok;
      // Read data lags the address by one cycle, so the slot lags the counter
      r_wr_en   <= (r_state == ST_RUN);
      r_wr_slot <= r_cnt;
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt + 1'b1;
      end
      for (int n = 0; n < NEURONS; n++) begin
        if (r_wr_en && (r_wr_slot == C_NFW'(n))) begin
          r_out_data[n*OBW +: OBW] <= w_rd_data;
        end
      end
    end
  end

  assign out_data = r_out_data;
  assign cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_lut_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_layer_sequencer
// Purpose  : Self-checking bench for lut_layer_sequencer with a behavioural
//            layer model (truth tables and connectivity as plain arrays).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_layer_sequencer;
  import lut_layer_sequencer_pkg::*;

  localparam int NIN  = DEF_IN_WIDTH;
  localparam int IBWB = DEF_IBW;
  localparam int FI   = DEF_FANIN;
  localparam int NN   = DEF_NEURONS;
  localparam int OB   = DEF_OBW;
  localparam int IW   = NIN * IBWB;
  localparam int OW   = NN * OB;
  localparam int NE   = 1 << TAW;
  // out_valid is seen NEURONS+1 edges after the accepting edge (cycle T+NEURONS+2)
  localparam int LAT_EDGES = NN + 1;

  typedef struct {
    logic [IW-1:0] vin;
    logic [OW-1:0] vexp;
  } vec_t;

  logic              clk;
  logic              rst;
  logic [IW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [OW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              cfg_we;
  logic              cfg_sel;
  logic [CFG_AW-1:0] cfg_addr;
  logic [CFG_DW-1:0] cfg_data;
  logic              cfg_err;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural reference: the layer as arrays
  logic [OB-1:0] m_tbl  [NN][NE];
  int            m_conn [NN][FI];

  lut_layer_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_addr(input int n, input logic [IW-1:0] v);
    int a;
    int idx;
    int f;
    a = 0;
    for (int k = 0; k < FI; k++) begin
      idx = m_conn[n][k];
      f   = (idx < NIN) ? int'((v >> (idx * IBWB)) & ((1 << IBWB) - 1)) : 0;
      a   = a | (f << (k * IBWB));
    end
    return a;
  endfunction

  function automatic logic [OW-1:0] model_out(input logic [IW-1:0] v);
    logic [OW-1:0] r;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      r[n*OB +: OB] = m_tbl[n][model_addr(n, v)];
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One config write issued from IDLE; the model follows legal writes only
  task automatic cfg_write(input logic sel, input int addr, input int data, input bit chk);
    bit ok;
    ok = (sel == CFG_SEL_CONN) ? (addr < NN * FI) : ((addr >> TAW) < NN);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = CFG_AW'(addr);
    cfg_data = CFG_DW'(data);
    tick();
    cfg_we = 1'b0;
    if (ok) begin
      if (sel == CFG_SEL_CONN) m_conn[addr / FI][addr % FI] = data & ((1 << IDXW) - 1);
      else                     m_tbl[addr >> TAW][addr & (NE - 1)] = OB'(data);
    end
    if (chk) check("cfg_err after write", cfg_err, !ok);
  endtask

  task automatic wait_out(input string nm, output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) check({nm, " out_valid timeout"}, 0, 1);
  endtask

  task automatic run_vector(input logic [IW-1:0] vin, input logic [OW-1:0] vexp,
                            input string nm, input int hold);
    int i;
    int lat;
    i = 0;
    while (!in_ready && i < 50) begin
      tick();
      i++;
    end
    if (!in_ready) check({nm, " in_ready timeout"}, 0, 1);
    in_valid = 1'b1;
    in_data  = vin;
    tick();
    in_valid = 1'b0;
    wait_out(nm, lat);
    check({nm, " latency"}, lat, LAT_EDGES);
    check({nm, " out_data"}, out_data, vexp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({nm, " held out_valid"}, out_valid, 1);
      check({nm, " held in_ready"}, in_ready, 0);
      check({nm, " held out_data"}, out_data, vexp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({nm, " out_valid after handshake"}, out_valid, 0);
    check({nm, " in_ready after handshake"}, in_ready, 1);
  endtask

  initial begin
    vec_t          vt [5];
    logic [IW-1:0] v;
    logic [IW-1:0] v2;
    logic [OW-1:0] e_out;
    logic [OB-1:0] newval;
    int            a_sel;
    int            pulses;
    int            lat;

    vt[0] = '{vin: IW'(32'hE4E4_E4E4), vexp: OW'(32'hE4E4_E4E4)};
    vt[1] = '{vin: IW'(32'h0000_0000), vexp: OW'(32'h0000_0000)};
    vt[2] = '{vin: IW'(32'hFFFF_FFFF), vexp: OW'(32'hFFFF_FFFF)};
    vt[3] = '{vin: IW'(32'h1234_5678), vexp: OW'(32'h1234_5678)};
    vt[4] = '{vin: IW'(32'hA5A5_0F3C), vexp: OW'(32'hA5A5_0F3C)};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_sel = CFG_SEL_TABLE; cfg_addr = '0; cfg_data = '0;
    repeat (3) tick();
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset cfg_err", cfg_err, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    tick();

    // Identity layer: entry = a[OB-1:0], first fan-in of neuron n is feature n
    for (int n = 0; n < NN; n++)
      for (int e = 0; e < NE; e++)
        cfg_write(CFG_SEL_TABLE, (n << TAW) | e, e & ((1 << OB) - 1), 1'b0);
    for (int n = 0; n < NN; n++)
      for (int k = 0; k < FI; k++)
        cfg_write(CFG_SEL_CONN, n * FI + k, (k == 0) ? n : int'($urandom_range(0, NIN - 1)), 1'b0);
    for (int i = 0; i < 5; i++) run_vector(vt[i].vin, vt[i].vexp, "ident", 0);

    // Back-pressure
    v = IW'($urandom);
    run_vector(v, model_out(v), "backpressure", 20);

    // Config write while running targets exactly the entry neuron 5 will read
    v      = IW'($urandom);
    e_out  = model_out(v);
    a_sel  = model_addr(5, v);
    in_valid = 1'b1; in_data = v;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("busy during run", busy, 1);
    cfg_we = 1'b1; cfg_sel = CFG_SEL_TABLE;
    cfg_addr = CFG_AW'((5 << TAW) | a_sel);
    cfg_data = CFG_DW'(~m_tbl[5][a_sel]);
    tick();
    cfg_we = 1'b0;
    pulses = cfg_err ? 1 : 0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      if (cfg_err) pulses++;
      lat++;
    end
    check("busy cfg_err pulse count", pulses, 1);
    check("busy cfg result", out_data, e_out);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    run_vector(v, e_out, "busy cfg rerun", 0);

    // Reset in the middle of RUN at cnt = 7
    v = IW'(32'hFFFF_FFFF);
    in_valid = 1'b1; in_data = v;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("busy before mid reset", busy, 1);
    rst = 1'b1;
    tick();
    check("mid reset out_valid", out_valid, 0);
    check("mid reset out_data", out_data, 0);
    check("mid reset in_ready", in_ready, 1);
    check("mid reset busy", busy, 0);
    rst = 1'b0;
    v = IW'($urandom);
    run_vector(v, model_out(v), "after mid reset", 0);

    // Out-of-range connectivity addresses are dropped
    cfg_write(CFG_SEL_CONN, NN * FI, 7, 1'b1);
    cfg_write(CFG_SEL_CONN, (1 << CFG_AW) - 1, 9, 1'b1);
    cfg_write(CFG_SEL_CONN, 1, int'($urandom_range(0, NIN - 1)), 1'b1);
    v = IW'(32'h0000_C000);
    run_vector(v, model_out(v), "oor conn kept", 0);

    // Config write and input acceptance in the same IDLE cycle
    v      = IW'($urandom);
    v2     = v ^ IW'(1 << (2 * IBWB));
    a_sel  = model_addr(2, v2);
    e_out  = model_out(v);
    newval = ~m_tbl[2][a_sel];
    in_valid = 1'b1; in_data = v;
    cfg_we = 1'b1; cfg_sel = CFG_SEL_TABLE;
    cfg_addr = CFG_AW'((2 << TAW) | a_sel);
    cfg_data = CFG_DW'(newval);
    tick();
    in_valid = 1'b0; cfg_we = 1'b0;
    check("simul cfg_err", cfg_err, 0);
    check("simul accepted", busy, 1);
    m_tbl[2][a_sel] = newval;
    wait_out("simul", lat);
    check("simul result", out_data, e_out);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    run_vector(v2, model_out(v2), "simul write visible", 0);

    // Sparse: only neuron 3 entry 0x1B is non-zero
    for (int n = 0; n < NN; n++)
      for (int e = 0; e < NE; e++)
        cfg_write(CFG_SEL_TABLE, (n << TAW) | e, 0, 1'b0);
    cfg_write(CFG_SEL_TABLE, (3 << TAW) | 8'h1B, 3, 1'b0);
    for (int k = 0; k < FI; k++) cfg_write(CFG_SEL_CONN, 3 * FI + k, k, 1'b0);
    v = {IW'($urandom) & ~IW'(8'hFF)} | IW'(8'h1B);
    run_vector(v, OW'(32'h0000_00C0), "sparse", 0);

    // Randomised layer against the model
    for (int n = 0; n < NN; n++)
      for (int e = 0; e < NE; e++)
        cfg_write(CFG_SEL_TABLE, (n << TAW) | e, int'($urandom), 1'b0);
    for (int n = 0; n < NN; n++)
      for (int k = 0; k < FI; k++)
        cfg_write(CFG_SEL_CONN, n * FI + k, int'($urandom_range(0, NIN - 1)), 1'b0);
    for (int i = 0; i < 25; i++) begin
      v = IW'($urandom);
      run_vector(v, model_out(v), "random", int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
